irq_ctrl: RTL and testbench

- Parametrised interrupt controller that replaces the fixed four-line interrupt wiring between peripherals and the CPU.
- Sits on the data-memory/IO bus at BASE_ADDR.
- Collects NUM_IRQ peripheral flags, each configurable as edge or level, with per-source enable, pending latch, fixed priority and a request/acknowledge/done handshake to the CPU.
- Issues one-cycle clear pulses back to the originating peripheral on acknowledge.

---
 rtl/irq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_irq_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Parametrised interrupt controller: per-source edge/level capture, enable, pending,
// fixed lowest-index-first priority and a req/ack/done handshake toward the CPU.
module irq_ctrl #(
   parameter int          NUM_IRQ   = 8,
   parameter logic [15:0] BASE_ADDR = 16'h1100
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [15:0]        address,
   input  logic [7:0]         din,
   input  logic               w_en,
   input  logic               r_en,
   output logic [7:0]         dout,
   input  logic [NUM_IRQ-1:0] irq_src,
   output logic [NUM_IRQ-1:0] irq_src_clr,
   output logic               irq_req,
   output logic [2:0]         irq_vector,
   input  logic               irq_ack,
   input  logic               irq_done
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_ACTIVE = 2'd2} state_t;

   function automatic logic [7:0] pad8(input logic [NUM_IRQ-1:0] v);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < NUM_IRQ; i++) p[i] = v[i];
      return p;
   endfunction

   function automatic logic [2:0] prio(input logic [NUM_IRQ-1:0] c);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (c[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   function automatic logic [NUM_IRQ-1:0] onehot(input logic [2:0] vec);
      logic [NUM_IRQ-1:0] oh;
      for (int i = 0; i < NUM_IRQ; i++) oh[i] = (3'(i) == vec);
      return oh;
   endfunction

   function automatic logic bit_at(input logic [2:0] vec, input logic [NUM_IRQ-1:0] v);
      logic b;
      b = 1'b0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (3'(i) == vec) b = v[i];
      end
      return b;
   endfunction

   state_t             r_state, w_state_nxt;
   logic [NUM_IRQ-1:0] r_ie, r_ip, r_mode, r_src_q, r_clr;
   logic               r_gie, r_req;
   logic [2:0]         r_vector;
   logic [7:0]         r_dout;

   logic [15:0]        w_off;
   logic               w_hit;
   logic [NUM_IRQ-1:0] w_din, w_cand, w_ip_nxt, w_clr_nxt;
   logic [2:0]         w_vector_nxt;
   logic               w_take;

   assign w_off = address - BASE_ADDR;
   assign w_hit = (w_off < 16'd5);
   assign w_din = din[NUM_IRQ-1:0];
   assign w_cand = r_ip & r_ie;

   assign dout        = r_dout;
   assign irq_req     = r_req;
   assign irq_vector  = r_vector;
   assign irq_src_clr = r_clr;

   // Pending update: W1C and ack clear first, then hardware set so a same-cycle set wins.
   always_comb begin
      w_ip_nxt = r_ip;
      w_ip_nxt = (w_en && w_hit && w_off == 16'd1) ? (w_ip_nxt & ~(w_din & r_mode)) : w_ip_nxt;
      w_ip_nxt = w_take ? (w_ip_nxt & ~(onehot(r_vector) & r_mode)) : w_ip_nxt;
      w_ip_nxt = w_ip_nxt | (irq_src & ~r_src_q & r_mode);
      w_ip_nxt = (w_ip_nxt & r_mode) | (irq_src & ~r_mode);
   end

   // Configuration registers, pending latch and edge-detect history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ie    <= '0;
         r_ip    <= '0;
         r_mode  <= '0;
         r_gie   <= 1'b0;
         r_src_q <= '0;
      end else begin
         r_ip    <= w_ip_nxt;
         r_src_q <= irq_src;
         if (w_en && w_hit) begin
            case (w_off)
               16'd0:   r_ie   <= w_din;
               16'd2:   r_mode <= w_din;
               16'd4:   r_gie  <= din[0];
               default: r_gie  <= r_gie;
            endcase
         end
      end
   end

   // Registered read port; holds when no read strobe is present.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout <= 8'h00;
      end else if (r_en) begin
         if (w_hit) begin
            case (w_off)
               16'd0:   r_dout <= pad8(r_ie);
               16'd1:   r_dout <= pad8(r_ip);
               16'd2:   r_dout <= pad8(r_mode);
               16'd3:   r_dout <= {(r_state == S_ACTIVE), 4'b0000, r_vector};
               16'd4:   r_dout <= {7'b0000000, r_gie};
               default: r_dout <= 8'h00;
            endcase
         end else begin
            r_dout <= 8'h00;
         end
      end
   end

   // Handshake next-state; an ack in the same cycle as a withdraw condition is honoured.
   always_comb begin
      w_state_nxt  = r_state;
      w_vector_nxt = r_vector;
      w_clr_nxt    = '0;
      w_take       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_gie && (w_cand != '0)) begin
               w_vector_nxt = prio(w_cand);
               w_state_nxt  = S_REQ;
            end else begin
               w_state_nxt  = S_IDLE;
            end
         end
         S_REQ: begin
            if (irq_ack) begin
               w_clr_nxt   = onehot(r_vector);
               w_take      = 1'b1;
               w_state_nxt = S_ACTIVE;
            end else if (!(r_gie && bit_at(r_vector, w_cand))) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_REQ;
            end
         end
         S_ACTIVE: begin
            if (irq_done) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_ACTIVE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Handshake state and registered CPU-facing outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_vector <= 3'd0;
         r_req    <= 1'b0;
         r_clr    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_vector <= w_vector_nxt;
         r_req    <= (w_state_nxt == S_REQ);
         r_clr    <= w_clr_nxt;
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: hand-computed expectations checked with immediate assertions.
module tb_irq_ctrl;

   localparam logic [15:0] BASE = 16'h1100;

   logic        clk, rst;
   logic [15:0] address;
   logic [7:0]  din, dout;
   logic        w_en, r_en;
   logic [7:0]  irq_src, irq_src_clr;
   logic        irq_req;
   logic [2:0]  irq_vector;
   logic        irq_ack, irq_done;
   logic [7:0]  rd;

   int n_chk  = 0;
   int n_pass = 0;

   irq_ctrl #(.NUM_IRQ(8), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .address(address), .din(din), .w_en(w_en), .r_en(r_en),
      .dout(dout), .irq_src(irq_src), .irq_src_clr(irq_src_clr), .irq_req(irq_req),
      .irq_vector(irq_vector), .irq_ack(irq_ack), .irq_done(irq_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
   endtask

   task automatic bus_write(input logic [15:0] off, input logic [7:0] data);
      address = BASE + off;
      din     = data;
      w_en    = 1'b1;
      tick();
      w_en    = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] addr, output logic [7:0] data);
      address = addr;
      r_en    = 1'b1;
      tick();
      r_en    = 1'b0;
      data    = dout;
   endtask

   initial begin
      rst = 1'b1; address = 16'h0000; din = 8'h00; w_en = 1'b0; r_en = 1'b0;
      irq_src = 8'h00; irq_ack = 1'b0; irq_done = 1'b0;
      tick(); tick();
      chk("rst_req", {7'd0, irq_req}, 8'h00);
      chk("rst_clr", irq_src_clr, 8'h00);
      chk("rst_dout", dout, 8'h00);
      chk("rst_vec", {5'd0, irq_vector}, 8'h00);
      rst = 1'b0;
      tick();

      // register readback and unmapped reads
      bus_write(16'd0, 8'hA5);
      bus_read(BASE, rd);          chk("ie_rb", rd, 8'hA5);
      bus_read(BASE + 16'd5, rd);  chk("off5", rd, 8'h00);
      bus_read(16'h0000, rd);      chk("unmapped", rd, 8'h00);
      tick();
      chk("dout_hold", dout, 8'h00);

      // edge single source 2
      bus_write(16'd2, 8'hFF);
      bus_write(16'd0, 8'h04);
      bus_write(16'd4, 8'h01);
      irq_src = 8'h04; tick();
      chk("e_lat_n1", {7'd0, irq_req}, 8'h00);
      irq_src = 8'h00; tick();
      chk("e_req", {7'd0, irq_req}, 8'h01);
      chk("e_vec", {5'd0, irq_vector}, 8'h02);
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      chk("e_clr", irq_src_clr, 8'h04);
      chk("e_req_off", {7'd0, irq_req}, 8'h00);
      tick();
      chk("e_clr_1cyc", irq_src_clr, 8'h00);
      bus_read(BASE + 16'd1, rd);  chk("e_ip", rd, 8'h00);
      bus_read(BASE + 16'd3, rd);  chk("e_stat_act", rd, 8'h82);
      irq_done = 1'b1; tick(); irq_done = 1'b0;
      bus_read(BASE + 16'd3, rd);  chk("e_stat_idle", rd, 8'h02);
      chk("e_idle_req", {7'd0, irq_req}, 8'h00);

      // priority: sources 5 and 1 together
      bus_write(16'd0, 8'h22);
      irq_src = 8'h22; tick();
      irq_src = 8'h00; tick();
      chk("p_req", {7'd0, irq_req}, 8'h01);
      chk("p_vec1", {5'd0, irq_vector}, 8'h01);
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      chk("p_clr1", irq_src_clr, 8'h02);
      bus_read(BASE + 16'd1, rd);  chk("p_ip", rd, 8'h20);
      irq_done = 1'b1; tick(); irq_done = 1'b0;
      chk("p_idle", {7'd0, irq_req}, 8'h00);
      tick();
      chk("p_req5", {7'd0, irq_req}, 8'h01);
      chk("p_vec5", {5'd0, irq_vector}, 8'h05);
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      chk("p_clr5", irq_src_clr, 8'h20);
      irq_done = 1'b1; tick(); irq_done = 1'b0;

      // withdraw: disable source 3 while requesting
      bus_write(16'd0, 8'h08);
      irq_src = 8'h08; tick();
      irq_src = 8'h00; tick();
      chk("w_req", {7'd0, irq_req}, 8'h01);
      chk("w_vec", {5'd0, irq_vector}, 8'h03);
      bus_write(16'd0, 8'h00);
      chk("w_clr_a", irq_src_clr, 8'h00);
      tick();
      chk("w_req_drop", {7'd0, irq_req}, 8'h00);
      chk("w_clr_b", irq_src_clr, 8'h00);
      bus_read(BASE + 16'd1, rd);  chk("w_ip", rd, 8'h08);
      bus_write(16'd1, 8'h08);
      bus_read(BASE + 16'd1, rd);  chk("w_ip_w1c", rd, 8'h00);

      // asynchronous reset in the middle of a request
      bus_write(16'd0, 8'h08);
      irq_src = 8'h08; tick();
      irq_src = 8'h00; tick();
      chk("r_req_pre", {7'd0, irq_req}, 8'h01);
      #2 rst = 1'b1;
      #1;
      chk("r_req_async", {7'd0, irq_req}, 8'h00);
      chk("r_clr_async", irq_src_clr, 8'h00);
      tick();
      rst = 1'b0;
      tick();
      bus_read(BASE, rd);          chk("r_ie_zero", rd, 8'h00);

      // level mode on source 0
      bus_write(16'd0, 8'h01);
      irq_src = 8'h01; tick(); tick();
      bus_read(BASE + 16'd1, rd);  chk("l_ip", rd, 8'h01);
      bus_write(16'd1, 8'h01);
      bus_read(BASE + 16'd1, rd);  chk("l_ip_w1c", rd, 8'h01);
      bus_write(16'd4, 8'h01);
      tick();
      chk("l_req", {7'd0, irq_req}, 8'h01);
      chk("l_vec", {5'd0, irq_vector}, 8'h00);
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      chk("l_clr", irq_src_clr, 8'h01);
      irq_src = 8'h00; tick(); tick();
      bus_read(BASE + 16'd1, rd);  chk("l_ip_drop", rd, 8'h00);
      irq_done = 1'b1; tick(); irq_done = 1'b0;

      // set/clear collision on an edge-mode bit
      bus_write(16'd0, 8'h00);
      bus_write(16'd2, 8'h01);
      address = BASE + 16'd1; din = 8'h01; w_en = 1'b1; irq_src = 8'h01;
      tick();
      w_en = 1'b0;
      bus_read(BASE + 16'd1, rd);  chk("c_set_wins", rd, 8'h01);
      bus_write(16'd1, 8'h01);
      bus_read(BASE + 16'd1, rd);  chk("c_w1c", rd, 8'h00);
      irq_src = 8'h00;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
